// File: rtl/k12a_lcd_pkg.sv
// Shared definitions for the K12a LCD bus master.
// Contains the controller FSM states, the bus-cycle engine phases, the
// I/O address map, and the bit positions of the status and control registers.
package k12a_lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_POLL  = 2'd3
  } lcd_state_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ENABLE = 2'd2,
    PH_HOLD   = 2'd3
  } cyc_phase_e;

  localparam logic [2:0] LCD_CTRL_ADDR = 3'd3;
  localparam logic [2:0] LCD_CMD_ADDR  = 3'd6;
  localparam logic [2:0] LCD_DATA_ADDR = 3'd7;

  // Bit positions in the status register (addr 3, load side).
  localparam int STAT_READY    = 7;
  localparam int STAT_RD_VALID = 6;
  localparam int STAT_OVERRUN  = 5;
  localparam int STAT_TIMEOUT  = 4;

  // Bit positions in the control register (addr 3, store side).
  localparam int CTRL_START = 0;
  localparam int CTRL_RS    = 1;
  localparam int CTRL_CLEAR = 7;

endpackage

// File: rtl/k12a_lcd_cycle.sv
// Timed HD44780 bus-cycle engine. It runs one SETUP -> ENABLE -> HOLD cycle
// for each start pulse.
// Ports:
//   cpu_clock, reset_n    clock and asynchronous active-low reset
//   start_i               begin a cycle; accepted when idle or in the done cycle
//   rs_i, rw_i, wdata_i   cycle attributes, captured together with start_i
//   lcd_data_i            LCD pad input, sampled in the last ENABLE cycle
//   done_o                high during the final HOLD cycle
//   rdata_o               byte sampled from the LCD
//   lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o, lcd_oe_o   pad signals
//   phase_o               current engine phase (debug)
module k12a_lcd_cycle
  import k12a_lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES  = 1
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] lcd_data_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_oe_o,
  output cyc_phase_e phase_o
);

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

  cyc_phase_e phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d, rw_q, rw_d, oe_q, oe_d;

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 8'd0;
      data_q  <= 8'd0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    data_d  = data_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    done_o  = 1'b0;
    case (phase_q)
      PH_SETUP: begin
        if (cnt_q == 8'd0) begin
          phase_d = PH_ENABLE;
          cnt_d   = PULSE_LAST;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PH_ENABLE: begin
        if (cnt_q == 8'd0) begin
          phase_d = PH_HOLD;
          cnt_d   = HOLD_LAST;
          rdata_d = lcd_data_i;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PH_HOLD: begin
        if (cnt_q == 8'd0) begin
          done_o  = 1'b1;
          phase_d = PH_IDLE;
          oe_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: ;
    endcase
    // A start in the done cycle chains the next cycle with no idle gap,
    // which keeps busy-flag polls back to back.
    if (start_i && (phase_q == PH_IDLE || done_o)) begin
      phase_d = PH_SETUP;
      cnt_d   = SETUP_LAST;
      rs_d    = rs_i;
      rw_d    = rw_i;
      oe_d    = !rw_i;
      if (!rw_i) data_d = wdata_i;
    end
  end

  assign rdata_o    = rdata_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = rw_q;
  assign lcd_en_o   = (phase_q == PH_ENABLE);
  assign lcd_data_o = data_q;
  assign lcd_oe_o   = oe_q;
  assign phase_o    = phase_q;

endmodule

// File: rtl/k12a_lcd_ctrl.sv
// HD44780-style LCD bus master on the K12a I/O bus.
// The store side accepts command writes (addr 6), data writes (addr 7) and
// control writes (addr 3). The load side returns status (addr 3) and the read
// buffer (addr 7). Every write is followed by automatic busy-flag polling.
// Ports:
//   cpu_clock, reset_n          clock and asynchronous active-low reset
//   io_load, io_store, io_addr  CPU I/O strobes and register select
//   data_bus                    shared CPU data bus; driven only on loads of 3 and 7
//   lcd_rs, lcd_rw, lcd_en      LCD control pins
//   lcd_data_out, lcd_data_oe   LCD data pad output and output enable
//   lcd_data_in                 LCD data pad input
module k12a_lcd_ctrl
  import k12a_lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned POLL_LIMIT   = 255
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       io_load,
  input  logic       io_store,
  input  logic [2:0] io_addr,
  inout  wire  [7:0] data_bus,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [7:0] lcd_data_in
);

  localparam logic [7:0] POLL_MAX = 8'(POLL_LIMIT);

  lcd_state_e state_q, state_d;
  logic [7:0] poll_q, poll_d;
  logic [7:0] rdbuf_q, rdbuf_d;
  logic       rd_rs_q, rd_rs_d;
  logic       rd_valid_q, overrun_q, timeout_q;
  logic       set_ovr, set_to, set_rv;
  logic       c_start, c_rs, c_rw, c_done;
  logic [7:0] c_rdata;
  logic [7:0] status;
  cyc_phase_e c_phase;

  wire wr_req  = io_store && (io_addr == LCD_CMD_ADDR || io_addr == LCD_DATA_ADDR);
  wire ctrl_st = io_store && (io_addr == LCD_CTRL_ADDR);
  wire rd_req  = ctrl_st && data_bus[CTRL_START];
  wire clr_req = ctrl_st && data_bus[CTRL_CLEAR];
  wire buf_ld  = io_load && (io_addr == LCD_DATA_ADDR);

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      poll_q     <= 8'd0;
      rdbuf_q    <= 8'd0;
      rd_rs_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      rdbuf_q    <= rdbuf_d;
      rd_rs_q    <= rd_rs_d;
      // Setting always wins over a clear at the same edge.
      rd_valid_q <= set_rv  || (rd_valid_q && !buf_ld);
      overrun_q  <= set_ovr || (overrun_q  && !clr_req);
      timeout_q  <= set_to  || (timeout_q  && !clr_req);
    end
  end

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    rdbuf_d = rdbuf_q;
    rd_rs_d = rd_rs_q;
    set_ovr = 1'b0;
    set_to  = 1'b0;
    set_rv  = 1'b0;
    c_start = 1'b0;
    c_rs    = 1'b0;   // default cycle is a status read
    c_rw    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          state_d = ST_WRITE;
          c_start = 1'b1;
          c_rs    = (io_addr == LCD_DATA_ADDR);
          c_rw    = 1'b0;
        end else if (rd_req) begin
          state_d = ST_READ;
          c_start = 1'b1;
          c_rs    = data_bus[CTRL_RS];
          rd_rs_d = data_bus[CTRL_RS];
        end
      end
      ST_WRITE: begin
        if (c_done) begin
          state_d = ST_POLL;
          c_start = 1'b1;
          poll_d  = 8'd0;
        end
      end
      ST_READ: begin
        if (c_done) begin
          rdbuf_d = c_rdata;
          set_rv  = 1'b1;
          if (rd_rs_q) begin
            state_d = ST_POLL;
            c_start = 1'b1;
            poll_d  = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_POLL: begin
        if (c_done) begin
          poll_d = poll_q + 8'd1;
          if (!c_rdata[7]) begin
            state_d = ST_IDLE;
          end else if (poll_d >= POLL_MAX) begin
            set_to  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            c_start = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && (wr_req || rd_req)) set_ovr = 1'b1;
  end

  k12a_lcd_cycle #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .PULSE_CYCLES (PULSE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_cycle (
    .cpu_clock  (cpu_clock),
    .reset_n    (reset_n),
    .start_i    (c_start),
    .rs_i       (c_rs),
    .rw_i       (c_rw),
    .wdata_i    (data_bus),
    .lcd_data_i (lcd_data_in),
    .done_o     (c_done),
    .rdata_o    (c_rdata),
    .lcd_rs_o   (lcd_rs),
    .lcd_rw_o   (lcd_rw),
    .lcd_en_o   (lcd_en),
    .lcd_data_o (lcd_data_out),
    .lcd_oe_o   (lcd_data_oe),
    .phase_o    (c_phase)
  );

  assign status = {(state_q == ST_IDLE), rd_valid_q, overrun_q, timeout_q, 4'h0};

  assign data_bus = (io_load && io_addr == LCD_CTRL_ADDR) ? status  :
                    buf_ld                                ? rdbuf_q : 8'hzz;

endmodule

// File: tb/tb_k12a_lcd_ctrl.sv
// Directed testbench for k12a_lcd_ctrl, with a small HD44780 model that answers
// status and data reads.
module tb_k12a_lcd_ctrl;

  logic       cpu_clock = 1'b0;
  logic       reset_n   = 1'b0;
  logic       io_load   = 1'b0;
  logic       io_store  = 1'b0;
  logic [2:0] io_addr   = 3'd0;
  logic [7:0] bus_drv   = 8'd0;
  logic       bus_oe    = 1'b0;
  wire  [7:0] data_bus;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_data_oe;
  logic [7:0] lcd_data_out;
  logic [7:0] lcd_data_in = 8'd0;

  int n_vec  = 0;
  int n_miss = 0;

  // LCD model state
  int         poll_total = 0, wr_total = 0, rd_total = 0;
  int         poll_base  = 0, busy_polls = 0;
  logic [7:0] read_byte  = 8'd0;
  logic       en_prev    = 1'b0;

  assign data_bus = bus_oe ? bus_drv : 8'hzz;

  // An undriven bus reads as all ones.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  k12a_lcd_ctrl #(.POLL_LIMIT(4)) dut (
    .cpu_clock    (cpu_clock),
    .reset_n      (reset_n),
    .io_load      (io_load),
    .io_store     (io_store),
    .io_addr      (io_addr),
    .data_bus     (data_bus),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .lcd_data_in  (lcd_data_in)
  );

  // ---------------- clock / reset ----------------
  always #5 cpu_clock = ~cpu_clock;

  // ---------------- LCD model ----------------
  // On each rising lcd_en, count the cycle type and present read data.
  // busy_polls sets how many status reads after poll_base report busy.
  always @(negedge cpu_clock) begin
    if (lcd_en && !en_prev) begin
      if (!lcd_rw) begin
        wr_total++;
      end else if (!lcd_rs) begin
        lcd_data_in = ((poll_total - poll_base) < busy_polls) ? 8'h80 : 8'h00;
        poll_total++;
      end else begin
        lcd_data_in = read_byte;
        rd_total++;
      end
    end
    en_prev = lcd_en;
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cpu_store(input logic [2:0] a, input logic [7:0] d);
    @(posedge cpu_clock); #1;
    io_addr = a; bus_drv = d; bus_oe = 1'b1; io_store = 1'b1;
    @(posedge cpu_clock); #1;
    io_store = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic cpu_load(input logic [2:0] a, output logic [7:0] d);
    @(posedge cpu_clock); #1;
    io_addr = a; io_load = 1'b1;
    @(negedge cpu_clock);
    d = data_bus;
    @(posedge cpu_clock); #1;
    io_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 200 && !s[7]; k++) cpu_load(3'd3, s);
    chk(tag, 8'(s[7]), 8'h01);
  endtask

  task automatic arm_model(input int busy, input logic [7:0] rb);
    poll_base  = poll_total;
    busy_polls = busy;
    read_byte  = rb;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    int p0, w0, r0;
    bit seen;

    // 1: reset state
    repeat (3) @(negedge cpu_clock);
    chk("rst_en", 8'(lcd_en), 8'h00);
    chk("rst_oe", 8'(lcd_data_oe), 8'h00);
    chk("rst_rw", 8'(lcd_rw), 8'h01);
    reset_n = 1'b1;
    cpu_load(3'd3, v); chk("rst_status", v, 8'h80);
    cpu_load(3'd0, v); chk("addr0_float", v, 8'hff);
    cpu_load(3'd7, v); chk("rst_rdbuf", v, 8'h00);

    // 2: command write followed by 4 polls (3 busy)
    arm_model(3, 8'h00);
    p0 = poll_total; w0 = wr_total;
    cpu_store(3'd6, 8'h01);
    @(negedge cpu_clock);
    chk("w_setup_en", 8'(lcd_en), 8'h00);
    chk("w_rs", 8'(lcd_rs), 8'h00);
    chk("w_rw", 8'(lcd_rw), 8'h00);
    chk("w_data", lcd_data_out, 8'h01);
    chk("w_oe", 8'(lcd_data_oe), 8'h01);
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clock);
      chk("w_en_high", 8'(lcd_en), 8'h01);
    end
    @(negedge cpu_clock);
    chk("w_hold_en", 8'(lcd_en), 8'h00);
    chk("w_hold_oe", 8'(lcd_data_oe), 8'h01);
    chk("w_hold_data", lcd_data_out, 8'h01);
    @(negedge cpu_clock);
    chk("p_rw", 8'(lcd_rw), 8'h01);
    chk("p_oe", 8'(lcd_data_oe), 8'h00);
    chk("p_rs", 8'(lcd_rs), 8'h00);
    wait_idle("w_idle");
    chk("w_polls", 8'(poll_total - p0), 8'd4);
    chk("w_cycles", 8'(wr_total - w0), 8'd1);
    cpu_load(3'd3, v); chk("w_status", v, 8'h80);

    // 3: overrun while busy; a clear with a dropped request at the same edge keeps overrun
    arm_model(2, 8'h00);
    w0 = wr_total; r0 = rd_total;
    cpu_store(3'd6, 8'h01);
    cpu_store(3'd7, 8'h41);
    cpu_load(3'd3, v); chk("ovr_busy", v, 8'h20);
    cpu_store(3'd3, 8'h81);
    cpu_load(3'd3, v); chk("ovr_set_wins", v, 8'h20);
    wait_idle("ovr_idle");
    chk("ovr_cycles", 8'(wr_total - w0), 8'd1);
    chk("ovr_no_read", 8'(rd_total - r0), 8'd0);
    cpu_load(3'd3, v); chk("ovr_status", v, 8'hA0);
    cpu_store(3'd3, 8'h80);
    cpu_load(3'd3, v); chk("ovr_clear", v, 8'h80);

    // 4: data read (RS=1) then one poll
    arm_model(0, 8'h5A);
    p0 = poll_total; r0 = rd_total;
    cpu_store(3'd3, 8'h03);
    @(negedge cpu_clock);
    chk("r_rs", 8'(lcd_rs), 8'h01);
    chk("r_rw", 8'(lcd_rw), 8'h01);
    chk("r_oe", 8'(lcd_data_oe), 8'h00);
    wait_idle("r_idle");
    chk("r_reads", 8'(rd_total - r0), 8'd1);
    chk("r_polls", 8'(poll_total - p0), 8'd1);
    cpu_load(3'd3, v); chk("r_status", v, 8'hC0);
    cpu_load(3'd7, v); chk("r_rdbuf", v, 8'h5A);
    cpu_load(3'd3, v); chk("r_status_clr", v, 8'h80);

    // 5: stuck busy, POLL_LIMIT=4
    arm_model(100, 8'h00);
    p0 = poll_total;
    cpu_store(3'd6, 8'h01);
    wait_idle("to_idle");
    chk("to_polls", 8'(poll_total - p0), 8'd4);
    cpu_load(3'd3, v); chk("to_status", v, 8'h90);
    cpu_store(3'd3, 8'h80);
    cpu_load(3'd3, v); chk("to_clear", v, 8'h80);

    // 6: asynchronous reset in the middle of the enable pulse
    arm_model(0, 8'h00);
    cpu_store(3'd6, 8'h38);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge cpu_clock);
      if (lcd_en) seen = 1'b1;
    end
    chk("ar_en_seen", 8'(seen), 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_en", 8'(lcd_en), 8'h00);
    chk("ar_oe", 8'(lcd_data_oe), 8'h00);
    @(negedge cpu_clock);
    reset_n = 1'b1;
    w0 = wr_total;
    repeat (8) @(negedge cpu_clock);
    chk("ar_no_cycle", 8'(wr_total - w0), 8'd0);
    cpu_load(3'd3, v); chk("ar_status", v, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
